// File: rtl/program_loader.sv
// program_loader: streams a program image into the CPU RAM while holding the
// CPU in reset, then releases reset and pulses o_done. When idle the RAM port
// is a straight combinational pass-through of the CPU bus.
module program_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RESET_HOLD = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_load_start,
  input  logic [ADDR_WIDTH-1:0] i_base_address,
  input  logic [ADDR_WIDTH-1:0] i_length,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  input  logic [ADDR_WIDTH-1:0] i_cpu_address,
  input  logic [DATA_WIDTH-1:0] i_cpu_data,
  input  logic                  i_cpu_ram_in,
  output logic [ADDR_WIDTH-1:0] o_ram_address,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_write,
  output logic                  o_cpu_reset,
  output logic                  o_busy,
  output logic                  o_done
);

  // Count needs one extra bit so a length of 0 can mean a full-depth image.
  localparam int CW = ADDR_WIDTH + 1;
  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(2 ** ADDR_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  ram_wr_q, ram_wr_d;
  logic                  ready_q, ready_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  xfer;

  assign xfer = (state_q == S_LOAD) & i_data_valid & ready_q;

  // Next-state and next-register values; write strobe and done default low.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    hold_d     = hold_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_wr_d   = 1'b0;
    ready_d    = ready_q;
    cpu_rst_d  = cpu_rst_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_load_start) begin
          state_d   = S_LOAD;
          addr_d    = i_base_address;
          count_d   = (i_length == '0) ? FULL_COUNT : {1'b0, i_length};
          ready_d   = 1'b1;
          cpu_rst_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          ram_addr_d = addr_q;
          ram_data_d = i_data;
          ram_wr_d   = 1'b1;
          addr_d     = addr_q + 1'b1;
          count_d    = count_q - 1'b1;
          // Last byte: stop accepting now so nothing beyond the image slips in.
          if (count_q == CW'(1)) begin
            ready_d = 1'b0;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_HOLD;
        hold_d  = HW'(RESET_HOLD);
      end
      S_HOLD: begin
        if (hold_q <= HW'(1)) begin
          state_d   = S_IDLE;
          cpu_rst_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and loader output registers; async reset leaves RAM contents alone.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      hold_q     <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wr_q   <= 1'b0;
      ready_q    <= 1'b0;
      cpu_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wr_q   <= ram_wr_d;
      ready_q    <= ready_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // CPU owns the RAM port only while idle; otherwise loader registers drive it.
  assign o_ram_address = (state_q == S_IDLE) ? i_cpu_address : ram_addr_q;
  assign o_ram_data    = (state_q == S_IDLE) ? i_cpu_data    : ram_data_q;
  assign o_ram_write   = (state_q == S_IDLE) ? i_cpu_ram_in  : ram_wr_q;
  assign o_data_ready  = ready_q;
  assign o_cpu_reset   = cpu_rst_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a behavioural RAM captures every write, and a
// reference image is built from base/length/bytes with modular address math.
module tb_program_loader;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int RH = 2;
  localparam int DEPTH = 16;

  logic          i_clock = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_load_start = 1'b0;
  logic [AW-1:0] i_base_address = '0;
  logic [AW-1:0] i_length = '0;
  logic [DW-1:0] i_data = '0;
  logic          i_data_valid = 1'b0;
  logic          o_data_ready;
  logic [AW-1:0] i_cpu_address = '0;
  logic [DW-1:0] i_cpu_data = '0;
  logic          i_cpu_ram_in = 1'b0;
  logic [AW-1:0] o_ram_address;
  logic [DW-1:0] o_ram_data;
  logic          o_ram_write;
  logic          o_cpu_reset;
  logic          o_busy;
  logic          o_done;

  program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_HOLD(RH)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_load_start(i_load_start),
    .i_base_address(i_base_address), .i_length(i_length), .i_data(i_data),
    .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
    .i_cpu_address(i_cpu_address), .i_cpu_data(i_cpu_data), .i_cpu_ram_in(i_cpu_ram_in),
    .o_ram_address(o_ram_address), .o_ram_data(o_ram_data), .o_ram_write(o_ram_write),
    .o_cpu_reset(o_cpu_reset), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clock = ~i_clock;

  // Environment RAM plus write/done observers.
  logic [DW-1:0] mem [DEPTH] = '{default: '0};
  logic [DW-1:0] model_mem [DEPTH] = '{default: '0};
  int            cyc = 0;
  int            done_cnt = 0;
  int            wr_addr[$];
  logic [DW-1:0] wr_data[$];
  int            wr_cyc[$];

  always @(posedge i_clock) begin
    if (o_ram_write) begin
      mem[o_ram_address] <= o_ram_data;
      wr_addr.push_back(int'(o_ram_address));
      wr_data.push_back(o_ram_data);
      wr_cyc.push_back(cyc);
    end
    if (o_done) done_cnt <= done_cnt + 1;
    cyc <= cyc + 1;
  end

  int            pass_cnt = 0;
  int            chk_cnt = 0;
  logic [DW-1:0] stim[$];
  int            acc_cyc[$];
  int            exp_addr[$];
  logic [DW-1:0] exp_data[$];

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  // Reference: byte i of the image lands at (base+i) mod depth; length 0 is a full image.
  task automatic model_load(input int base, input int len);
    int n;
    n = (len == 0) ? DEPTH : len;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back((base + i) % DEPTH);
      exp_data.push_back(stim[i]);
      model_mem[(base + i) % DEPTH] = stim[i];
    end
  endtask

  // Drives one load; mode 0 back-to-back, 1 every third cycle, 2 random gaps.
  task automatic drive_load(input int base, input int len, input int mode, input bit misuse,
                            output int start_edge, output int last_acc, output int done_edge,
                            output int n_acc, output bit rst_ok, output bit timeout);
    int  idx;
    bit  v;
    bit  acc;
    i_base_address = AW'(base);
    i_length       = AW'(len);
    i_load_start   = 1'b1;
    acc_cyc.delete();
    step();
    i_load_start = 1'b0;
    start_edge = cyc - 1;
    last_acc   = start_edge;
    done_edge  = start_edge;
    rst_ok     = o_cpu_reset && o_busy && o_data_ready;
    timeout    = 1'b1;
    idx        = 0;
    for (int t = 0; t < 400; t++) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (t % 3 == 2);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      i_data_valid = v;
      i_data = (idx < stim.size()) ? stim[idx] : 8'h5A;
      if (misuse) begin
        i_load_start  = (t % 4 == 1);
        i_cpu_ram_in  = (t % 2 == 1);
        i_cpu_address = AW'($urandom);
        i_cpu_data    = DW'($urandom);
      end
      acc = v && o_data_ready;
      step();
      if (acc) begin
        acc_cyc.push_back(cyc);
        last_acc = cyc - 1;
        idx++;
      end
      if (o_done) begin
        done_edge = cyc - 1;
        timeout = 1'b0;
        break;
      end
      if (!o_cpu_reset) rst_ok = 1'b0;
    end
    i_data_valid = 1'b0;
    i_load_start = 1'b0;
    i_cpu_ram_in = 1'b0;
    n_acc = idx;
    repeat (3) step();
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    #1;
    chk_cnt++;
    if ({o_busy, o_cpu_reset, o_data_ready, o_done, o_ram_write} !== 5'b0)
      $display("FAIL reset_outputs: got %b expected 00000",
               {o_busy, o_cpu_reset, o_data_ready, o_done, o_ram_write});
    else pass_cnt++;
    step(); step();
    i_reset_n = 1'b1;
    step();
    i_cpu_address = 4'd9; i_cpu_data = 8'h3C; i_cpu_ram_in = 1'b1;
    #1;
    chk_cnt++;
    if ({o_ram_address, o_ram_data, o_ram_write} !== {4'd9, 8'h3C, 1'b1})
      $display("FAIL idle_passthrough: got %h/%h/%b expected 9/3c/1",
               o_ram_address, o_ram_data, o_ram_write);
    else pass_cnt++;
    step();
    model_mem[9] = 8'h3C;
    i_cpu_ram_in = 1'b0;
  endtask

  // Shared body for the ordinary load scenarios; each caller names its case.
  task automatic test_load(input string nm, input int base, input int len, input int mode,
                           input bit misuse, input bit fixed_lat);
    int se, la, de, na, w0, d0, n, bad, nw;
    bit rok, to;
    n  = (len == 0) ? DEPTH : len;
    w0 = wr_addr.size();
    d0 = done_cnt;
    model_load(base, len);
    drive_load(base, len, mode, misuse, se, la, de, na, rok, to);
    chk_cnt++;
    if (to) $display("FAIL %s_timeout: o_done not seen within budget", nm);
    else pass_cnt++;
    chk_cnt++;
    if (na !== n) $display("FAIL %s_accepts: got %0d expected %0d", nm, na, n);
    else pass_cnt++;
    nw = wr_addr.size() - w0;
    chk_cnt++;
    if (nw !== n) $display("FAIL %s_write_count: got %0d expected %0d", nm, nw, n);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < n && i < nw; i++) begin
      if (wr_addr[w0+i] !== exp_addr[i] || wr_data[w0+i] !== exp_data[i] ||
          i >= acc_cyc.size() || wr_cyc[w0+i] !== acc_cyc[i]) begin
        bad++;
        $display("note %s write %0d: addr %0d data %h (want %0d %h)", nm, i,
                 wr_addr[w0+i], wr_data[w0+i], exp_addr[i], exp_data[i]);
      end
    end
    chk_cnt++;
    if (bad !== 0) $display("FAIL %s_write_content: got %0d bad writes expected 0", nm, bad);
    else pass_cnt++;
    chk_cnt++;
    if (done_cnt - d0 !== 1) $display("FAIL %s_done_pulses: got %0d expected 1", nm, done_cnt - d0);
    else pass_cnt++;
    chk_cnt++;
    if (!rok) $display("FAIL %s_cpu_reset_held: got dropped expected held until done", nm);
    else pass_cnt++;
    chk_cnt++;
    if (de - la !== 1 + RH)
      $display("FAIL %s_release_latency: got %0d expected %0d", nm, de - la, 1 + RH);
    else pass_cnt++;
    if (fixed_lat) begin
      // Edges counted inclusive of the start edge.
      chk_cnt++;
      if (de - se + 1 !== 2 + n + RH)
        $display("FAIL %s_total_latency: got %0d expected %0d", nm, de - se + 1, 2 + n + RH);
      else pass_cnt++;
    end
    chk_cnt++;
    if ({o_busy, o_cpu_reset, o_done} !== 3'b0)
      $display("FAIL %s_idle_after: got %b expected 000", nm, {o_busy, o_cpu_reset, o_done});
    else pass_cnt++;
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== model_mem[a]) bad++;
    chk_cnt++;
    if (bad !== 0) $display("FAIL %s_ram_image: got %0d differing words expected 0", nm, bad);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    stim = '{8'h1E, 8'h2F, 8'hE0};
    test_load("b2b", 0, 3, 0, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    stim = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    test_load("wrap", 14, 4, 0, 1'b0, 1'b1);
  endtask

  task automatic test_full();
    stim.delete();
    for (int i = 0; i < DEPTH; i++) stim.push_back(DW'($urandom));
    test_load("full", int'($urandom_range(0, DEPTH - 1)), 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_gaps_ignore();
    stim = '{DW'($urandom), DW'($urandom)};
    test_load("gaps", int'($urandom_range(0, DEPTH - 1)), 2, 1, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 4; it++) begin
      len = int'($urandom_range(0, DEPTH - 1));
      stim.delete();
      for (int i = 0; i < DEPTH; i++) stim.push_back(DW'($urandom));
      test_load("rand", int'($urandom_range(0, DEPTH - 1)), len, 2, it[0], 1'b0);
    end
  endtask

  task automatic test_reset_midload();
    int base, d0, bad;
    base = int'($urandom_range(0, DEPTH - 1));
    stim.delete();
    for (int i = 0; i < 5; i++) stim.push_back(DW'($urandom));
    i_base_address = AW'(base); i_length = 4'd5; i_load_start = 1'b1;
    step();
    i_load_start = 1'b0;
    i_data_valid = 1'b1; i_data = stim[0];
    step();
    i_data = stim[1];
    step();
    i_data_valid = 1'b0;
    step();
    d0 = done_cnt;
    i_reset_n = 1'b0;
    #1;
    chk_cnt++;
    if ({o_busy, o_cpu_reset, o_data_ready, o_done, o_ram_write} !== 5'b0)
      $display("FAIL midload_reset_outputs: got %b expected 00000",
               {o_busy, o_cpu_reset, o_data_ready, o_done, o_ram_write});
    else pass_cnt++;
    step(); step();
    chk_cnt++;
    if (done_cnt !== d0) $display("FAIL midload_no_done: got %0d pulses expected 0", done_cnt - d0);
    else pass_cnt++;
    model_mem[base % DEPTH] = stim[0];
    model_mem[(base + 1) % DEPTH] = stim[1];
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== model_mem[a]) bad++;
    chk_cnt++;
    if (bad !== 0) $display("FAIL midload_partial_image: got %0d differing words expected 0", bad);
    else pass_cnt++;
    i_reset_n = 1'b1;
    step();
    i_cpu_address = 4'd5; i_cpu_data = 8'h77; i_cpu_ram_in = 1'b1;
    #1;
    chk_cnt++;
    if ({o_ram_address, o_ram_write} !== {4'd5, 1'b1})
      $display("FAIL midload_passthrough: got %h/%b expected 5/1", o_ram_address, o_ram_write);
    else pass_cnt++;
    step();
    model_mem[5] = 8'h77;
    i_cpu_ram_in = 1'b0;
    stim = '{DW'($urandom), DW'($urandom), DW'($urandom)};
    test_load("after_reset", int'($urandom_range(0, DEPTH - 1)), 3, 0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wrap();
    test_full();
    test_gaps_ignore();
    test_random();
    test_reset_midload();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
